// File: rtl/jtag_dap_sequencer.sv
// ADIv5 JTAG-DP/AP request sequencer: turns one register access into IR/DR scan
// packets for the JTAG PHY FIFO, retries on WAIT and fetches posted reads via RDBUFF.
module jtag_dap_sequencer #(
    parameter int MAX_CLEN    = 4096,
    parameter int BUF_SZ      = 64,
    parameter int CMD_WIDTH   = 3,
    parameter int IR_LEN      = 4,
    parameter int MAX_RETRY   = 15,
    parameter int LEN_W       = $clog2(MAX_CLEN),
    parameter int FIFO_IN_SZ  = BUF_SZ + CMD_WIDTH + LEN_W,
    parameter int FIFO_OUT_SZ = BUF_SZ + $clog2(BUF_SZ)
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   REQ_VALID,
    output logic                   REQ_READY,
    input  logic                   REQ_APnDP,
    input  logic [1:0]             REQ_ADDR,
    input  logic                   REQ_RnW,
    input  logic [31:0]            REQ_WDATA,
    output logic                   RESP_VALID,
    output logic [31:0]            RESP_RDATA,
    output logic [1:0]             RESP_ERR,
    output logic                   PHY_ENABLE,
    output logic [FIFO_IN_SZ-1:0]  PHY_WRDATA,
    output logic                   PHY_WREN,
    input  logic                   PHY_WRFULL,
    input  logic [FIFO_OUT_SZ-1:0] PHY_RDDATA,
    output logic                   PHY_RDEN,
    input  logic                   PHY_RDEMPTY
);

    localparam int ILEN_W  = $clog2(BUF_SZ);
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    localparam int SCAN_W  = 35;

    localparam logic [IR_LEN-1:0]    IR_DPACC = IR_LEN'(4'hA);
    localparam logic [IR_LEN-1:0]    IR_APACC = IR_LEN'(4'hB);
    localparam logic [CMD_WIDTH-1:0] CMD_TAP  = '0;
    localparam logic [CMD_WIDTH-1:0] CMD_IR   = CMD_WIDTH'(3'b100);
    localparam logic [CMD_WIDTH-1:0] CMD_DR   = CMD_WIDTH'(3'b001);
    localparam logic [LEN_W-1:0]     LEN_IR   = LEN_W'(IR_LEN);
    localparam logic [LEN_W-1:0]     LEN_DR   = LEN_W'(SCAN_W - 1);
    localparam logic [RETRY_W-1:0]   RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [2:0]           ACK_OK    = 3'b010;
    localparam logic [2:0]           ACK_WAIT  = 3'b001;
    localparam logic [2:0]           ACK_FAULT = 3'b100;

    typedef enum logic [3:0] {
        TAP_RST, IDLE, IR_SEL, DR_SEND, DR_WAIT, DR_POP, DR_CAP,
        RB_IR, RB_SEND, RB_WAIT, RB_POP, RB_CAP, RESP
    } state_t;

    state_t                  state_reg, state_next;
    logic [IR_LEN-1:0]       ir_cache_reg, ir_cache_next;
    logic                    ir_valid_reg, ir_valid_next;
    logic                    apndp_reg, apndp_next;
    logic [1:0]              addr_reg, addr_next;
    logic                    rnw_reg, rnw_next;
    logic [31:0]             wdata_reg, wdata_next;
    logic [RETRY_W-1:0]      retry_reg, retry_next;
    logic                    req_ready_reg, req_ready_next;
    logic                    resp_valid_reg, resp_valid_next;
    logic [31:0]             resp_rdata_reg, resp_rdata_next;
    logic [1:0]              resp_err_reg, resp_err_next;
    logic                    phy_enable_reg;
    logic                    wren_reg, wren_next;
    logic [FIFO_IN_SZ-1:0]   wrdata_reg, wrdata_next;
    logic                    rden_reg, rden_next;

    // Captured scan bit k sits at din[BUF_SZ-35+k]; din is above the ilen field.
    logic [SCAN_W-1:0] scan;
    genvar gi;
    generate
        for (gi = 0; gi < SCAN_W; gi++) begin : g_scan
            assign scan[gi] = PHY_RDDATA[ILEN_W + BUF_SZ - SCAN_W + gi];
        end
    endgenerate

    logic unused_rd_bits;
    assign unused_rd_bits = ^PHY_RDDATA[ILEN_W + BUF_SZ - SCAN_W - 1:0];

    logic [2:0]  ack;
    logic [31:0] rd_word;
    assign ack     = scan[2:0];
    assign rd_word = scan[SCAN_W-1:3];

    logic              in_rb;
    logic [IR_LEN-1:0] ir_need;
    logic [BUF_SZ-1:0] req_scan;
    logic [BUF_SZ-1:0] rdbuff_scan;
    assign in_rb       = (state_reg inside {RB_IR, RB_SEND, RB_WAIT, RB_POP, RB_CAP});
    assign ir_need     = (in_rb || !apndp_reg) ? IR_DPACC : IR_APACC;
    assign req_scan    = BUF_SZ'({wdata_reg, addr_reg, rnw_reg});
    assign rdbuff_scan = BUF_SZ'({32'h0, 2'b11, 1'b1});

    function automatic logic [FIFO_IN_SZ-1:0] pack(input logic [BUF_SZ-1:0] data,
                                                   input logic [LEN_W-1:0] len,
                                                   input logic [CMD_WIDTH-1:0] cmd);
        return {data, len, cmd};
    endfunction

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg      <= TAP_RST;
            ir_cache_reg   <= '0;
            ir_valid_reg   <= 1'b0;
            apndp_reg      <= 1'b0;
            addr_reg       <= '0;
            rnw_reg        <= 1'b0;
            wdata_reg      <= '0;
            retry_reg      <= '0;
            req_ready_reg  <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= '0;
            resp_err_reg   <= '0;
            phy_enable_reg <= 1'b0;
            wren_reg       <= 1'b0;
            wrdata_reg     <= '0;
            rden_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ir_cache_reg   <= ir_cache_next;
            ir_valid_reg   <= ir_valid_next;
            apndp_reg      <= apndp_next;
            addr_reg       <= addr_next;
            rnw_reg        <= rnw_next;
            wdata_reg      <= wdata_next;
            retry_reg      <= retry_next;
            req_ready_reg  <= req_ready_next;
            resp_valid_reg <= resp_valid_next;
            resp_rdata_reg <= resp_rdata_next;
            resp_err_reg   <= resp_err_next;
            phy_enable_reg <= 1'b1;
            wren_reg       <= wren_next;
            wrdata_reg     <= wrdata_next;
            rden_reg       <= rden_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        ir_cache_next   = ir_cache_reg;
        ir_valid_next   = ir_valid_reg;
        apndp_next      = apndp_reg;
        addr_next       = addr_reg;
        rnw_next        = rnw_reg;
        wdata_next      = wdata_reg;
        retry_next      = retry_reg;
        req_ready_next  = 1'b0;
        resp_valid_next = 1'b0;
        resp_rdata_next = resp_rdata_reg;
        resp_err_next   = resp_err_reg;
        wren_next       = 1'b0;
        wrdata_next     = wrdata_reg;
        rden_next       = 1'b0;

        case (state_reg)
            TAP_RST: begin
                if (!PHY_WRFULL) begin
                    wren_next     = 1'b1;
                    wrdata_next   = pack('0, '0, CMD_TAP);
                    ir_valid_next = 1'b0;
                    state_next    = IDLE;
                end
            end
            IDLE: begin
                if (REQ_VALID && req_ready_reg) begin
                    apndp_next = REQ_APnDP;
                    addr_next  = REQ_ADDR;
                    rnw_next   = REQ_RnW;
                    wdata_next = REQ_WDATA;
                    retry_next = '0;
                    state_next = IR_SEL;
                end
            end
            IR_SEL, RB_IR: begin
                if (in_rb) begin
                    retry_next = '0;
                end
                if (ir_valid_reg && (ir_cache_reg == ir_need)) begin
                    state_next = in_rb ? RB_SEND : DR_SEND;
                end else if (!PHY_WRFULL) begin
                    wren_next     = 1'b1;
                    wrdata_next   = pack(BUF_SZ'(ir_need), LEN_IR, CMD_IR);
                    ir_cache_next = ir_need;
                    ir_valid_next = 1'b1;
                    state_next    = in_rb ? RB_SEND : DR_SEND;
                end
            end
            DR_SEND, RB_SEND: begin
                if (!PHY_WRFULL) begin
                    wren_next   = 1'b1;
                    wrdata_next = pack(in_rb ? rdbuff_scan : req_scan, LEN_DR, CMD_DR);
                    state_next  = in_rb ? RB_WAIT : DR_WAIT;
                end
            end
            DR_WAIT, RB_WAIT: begin
                if (!PHY_RDEMPTY) begin
                    rden_next  = 1'b1;
                    state_next = in_rb ? RB_POP : DR_POP;
                end
            end
            // Response word is valid the cycle after the pop strobe.
            DR_POP, RB_POP: begin
                state_next = in_rb ? RB_CAP : DR_CAP;
            end
            DR_CAP, RB_CAP: begin
                if (ack == ACK_WAIT) begin
                    if (retry_reg < RETRY_MAX) begin
                        retry_next = retry_reg + RETRY_W'(1);
                        state_next = in_rb ? RB_SEND : DR_SEND;
                    end else begin
                        resp_err_next   = 2'd1;
                        resp_rdata_next = '0;
                        resp_valid_next = 1'b1;
                        state_next      = RESP;
                    end
                end else if (ack == ACK_OK) begin
                    if (in_rb) begin
                        resp_err_next   = 2'd0;
                        resp_rdata_next = rd_word;
                        resp_valid_next = 1'b1;
                        state_next      = RESP;
                    end else if (rnw_reg) begin
                        // Posted read: the real data comes from the RDBUFF scan.
                        state_next = RB_IR;
                    end else begin
                        resp_err_next   = 2'd0;
                        resp_rdata_next = '0;
                        resp_valid_next = 1'b1;
                        state_next      = RESP;
                    end
                end else begin
                    resp_err_next   = (ack == ACK_FAULT) ? 2'd2 : 2'd3;
                    resp_rdata_next = '0;
                    resp_valid_next = 1'b1;
                    state_next      = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = TAP_RST;
            end
        endcase

        req_ready_next = (state_next == IDLE);
    end

    assign REQ_READY  = req_ready_reg;
    assign RESP_VALID = resp_valid_reg;
    assign RESP_RDATA = resp_rdata_reg;
    assign RESP_ERR   = resp_err_reg;
    assign PHY_ENABLE = phy_enable_reg;
    assign PHY_WREN   = wren_reg;
    assign PHY_WRDATA = wrdata_reg;
    assign PHY_RDEN   = rden_reg;

endmodule

// File: doc/jtag_dap_sequencer.md
Name: jtag_dap_sequencer

Overview:
- Controller that turns single ARM ADIv5 JTAG-DP/AP register requests into scan packets for the JTAG PHY command FIFO, then parses the captured responses.
- Handles IR selection with an IR cache, WAIT retry, posted-read RDBUFF fetch, and the initial TAP reset.
- Sits between the AHB3-lite remote bridge front end and the JTAG PHY, in the same CLK domain as the PHY FIFO host side.

Parameters:
- MAX_CLEN, 4096, maximum scan chain length; sets LEN_W = $clog2(MAX_CLEN) = 12.
- BUF_SZ, 64, data bits per PHY packet; must be >= 35.
- CMD_WIDTH, 3, PHY command field width.
- IR_LEN, 4, DAP instruction register length.
- MAX_RETRY, 15, maximum WAIT retries per DR scan.
- FIFO_IN_SZ, BUF_SZ+CMD_WIDTH+LEN_W, width of a PHY request packet.
- FIFO_OUT_SZ, BUF_SZ+$clog2(BUF_SZ), width of a PHY response packet.

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous active-high reset
- REQ_VALID  in  1  request valid
- REQ_READY  out  1  sequencer can accept a request
- REQ_APnDP  in  1  1 = AP access, 0 = DP access
- REQ_ADDR  in  2  register address A[3:2]
- REQ_RnW  in  1  1 = read
- REQ_WDATA  in  32  write data
- RESP_VALID  out  1  one-cycle response strobe
- RESP_RDATA  out  32  read data (0 for writes)
- RESP_ERR  out  2  0 = OK, 1 = WAIT timeout, 2 = FAULT, 3 = invalid ACK
- PHY_ENABLE  out  1  PHY enable
- PHY_WRDATA  out  FIFO_IN_SZ  packet {data[BUF_SZ-1:0], len[LEN_W-1:0], cmd[2:0]}
- PHY_WREN  out  1  PHY request FIFO write
- PHY_WRFULL  in  1  PHY request FIFO full
- PHY_RDDATA  in  FIFO_OUT_SZ  PHY response {din[BUF_SZ-1:0], ilen}
- PHY_RDEN  out  1  PHY response FIFO read
- PHY_RDEMPTY  in  1  PHY response FIFO empty

Behaviour:
- Reset values: REQ_READY=0, RESP_VALID=0, RESP_RDATA=0, RESP_ERR=0, PHY_ENABLE=0, PHY_WREN=0, PHY_WRDATA=0, PHY_RDEN=0. IR cache is invalid. State = TAP_RST.
- PHY_ENABLE is driven to 1 on the first cycle after RESET deasserts and stays at 1.
- Packet encodings:
  - TAP reset: data=0, len=0, cmd=000.
  - IR write: data=IR value zero-extended, len=IR_LEN, cmd=100. No response is expected.
  - DR scan: data = {WDATA, A[3:2], RnW} in bits [34:0], len = 34 (read packets carry nbits-1), cmd=001. The response is always captured.
- IR values: DPACC = 4'hA, APACC = 4'hB.
- Response parsing: captured scan bit k is at din[BUF_SZ-35+k].
  - ACK = bits[2:0]: 3'b010 = OK/FAULT, 3'b001 = WAIT, any other value = invalid.
  - Read data = bits[34:3].
  - ilen is ignored.
  - FAULT status is reported by a DP CTRL/STAT read; the sequencer treats OK/FAULT ACK as OK and reports FAULT only when the ACK equals 3'b100.
- Write handshake: PHY_WREN pulses for exactly one cycle, only when PHY_WRFULL=0, with PHY_WRDATA stable that cycle. If PHY_WRFULL=1, the sequencer holds in the current state.
- Read handshake: PHY_RDEN pulses one cycle when PHY_RDEMPTY=0. PHY_RDDATA is sampled on the following cycle.
- At most one DR scan is outstanding at any time.
- States and transitions:
  - TAP_RST: issue the TAP reset packet, invalidate the IR cache, then go to IDLE.
  - IDLE: REQ_READY=1. On REQ_VALID & REQ_READY, latch the request, drop REQ_READY, zero the retry counter. Go to IR_SEL.
  - IR_SEL: if the IR cache equals the needed IR, skip to DR_SEND. Otherwise send the IR packet, update the cache, go to DR_SEND.
  - DR_SEND: send the request DR packet, go to DR_WAIT.
  - DR_WAIT: pop the response.
    - WAIT with retry < MAX_RETRY: increment retry, go back to DR_SEND.
    - WAIT at MAX_RETRY: ERR=1, go to RESP.
    - FAULT or invalid ACK: ERR=2 or 3, go to RESP.
    - OK: a write goes to RESP; a read goes to RB_IR.
  - RB_IR: select DPACC (through the cache), zero retry, go to RB_SEND.
  - RB_SEND: send DR {32'h0, A=2'b11, RnW=1} (RDBUFF read), go to RB_WAIT.
  - RB_WAIT: same ACK and retry rules as DR_WAIT. On OK, RESP_RDATA = data bits, go to RESP.
  - RESP: RESP_VALID=1 for one cycle, then go to IDLE.
- RESP_RDATA is 0 for writes and for any error response.
- The retry counter is $clog2(MAX_RETRY+1) bits wide and never wraps.
- RESET asserted mid-operation: all outputs return to their reset values next cycle. The sequencer restarts from TAP_RST. Stale PHY responses are not drained; the PHY is reset by the same system reset.

Test Plan:
- Release reset, PHY_WRFULL=0 -> one PHY_WREN with WRDATA={64'h0,12'd0,3'b000}; PHY_ENABLE=1; REQ_READY=1 afterwards.
- DP write A=2'b10, WDATA=32'h01000000 -> packet {64'hA,12'd4,3'b100}, then {64'h0000_0000_0800_0004,12'd34,3'b001}; respond ACK=010 -> RESP_VALID with ERR=0, RDATA=0.
- Repeat the same DP write -> no IR packet is issued (cache hit); only the DR packet is sent.
- AP read A=2'b00; respond WAIT twice then OK; RDBUFF response data 32'hDEADBEEF -> three APACC DR packets, IR 4'hA, one RDBUFF packet {..., 35'h7}; RESP_RDATA=32'hDEADBEEF, ERR=0.
- Always respond WAIT -> exactly MAX_RETRY+1=16 DR packets, then RESP_ERR=1. Respond ACK=3'b111 -> RESP_ERR=3.
- Hold PHY_WRFULL=1 for 10 cycles mid-request -> no PHY_WREN during those cycles; packet issued on the first cycle after WRFULL drops. Assert RESET in DR_WAIT -> outputs at reset values next cycle, then the TAP reset packet is reissued.
